// File: rtl/nec_ir_decoder.sv
// NEC IR frame decoder: times marks/spaces against tolerance windows, decodes 32-bit frames and repeats.
// Define NEC_IR_DECODER_CHECK_EN to enable command integrity check and 8/16-bit address detection.
module nec_ir_decoder #(
  parameter int CLOCK_HZ          = 50_000_000,
  parameter int TOLERANCE_PCT     = 25,
  parameter bit RX_ACTIVE_LOW     = 1'b1,
  parameter int REPEAT_TIMEOUT_MS = 120
) (
  input  logic        clkIN,
  input  logic        resetIN,
  input  logic        rxIN,
  output logic        dataValidOUT,
  output logic        repeatOUT,
  output logic        heldOUT,
  output logic        errorOUT,
  output logic        extendedOUT,
  output logic [15:0] addressOUT,
  output logic [7:0]  commandOUT,
  output logic [31:0] dataOUT
);

  localparam int T    = int'((64'(CLOCK_HZ) * 64'd5625) / 64'd10_000_000);
  localparam int SAT  = 20 * T + 1;
  localparam int CW   = $clog2(SAT + 1);
  localparam int HOLD = int'((64'(REPEAT_TIMEOUT_MS) * 64'(CLOCK_HZ)) / 64'd1000);
  localparam int HW   = $clog2(HOLD + 1);

  function automatic logic [CW-1:0] win(input int units, input int pct);
    return CW'(units * T * pct / 100);
  endfunction

  localparam logic [CW-1:0] LO1  = win(1,  100 - TOLERANCE_PCT);
  localparam logic [CW-1:0] HI1  = win(1,  100 + TOLERANCE_PCT);
  localparam logic [CW-1:0] LO3  = win(3,  100 - TOLERANCE_PCT);
  localparam logic [CW-1:0] HI3  = win(3,  100 + TOLERANCE_PCT);
  localparam logic [CW-1:0] LO4  = win(4,  100 - TOLERANCE_PCT);
  localparam logic [CW-1:0] HI4  = win(4,  100 + TOLERANCE_PCT);
  localparam logic [CW-1:0] LO8  = win(8,  100 - TOLERANCE_PCT);
  localparam logic [CW-1:0] HI8  = win(8,  100 + TOLERANCE_PCT);
  localparam logic [CW-1:0] LO16 = win(16, 100 - TOLERANCE_PCT);
  localparam logic [CW-1:0] HI16 = win(16, 100 + TOLERANCE_PCT);
  localparam logic [CW-1:0] SATV = CW'(SAT);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REPEAT_MARK
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, mark_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bits_q, bits_d;
  logic [31:0]   shift_q, shift_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          held_q, held_d;
  logic          dv_q, dv_d, rep_q, rep_d, err_q, err_d;
  logic          ext_q;
  logic [15:0]   addr_q;
  logic [7:0]    cmd_q;
  logic [31:0]   data_q;

  logic          mark, rise, fall, sat;
  logic          m1, m3, m4, m8, m16;
  logic          chk_ok, ext_pub;
  logic [15:0]   addr_pub;

  assign mark = sync2_q ^ RX_ACTIVE_LOW;
  assign rise = mark & ~mark_q;
  assign fall = ~mark & mark_q;
  assign sat  = (cnt_q == SATV);
  assign m1   = (cnt_q >= LO1)  && (cnt_q <= HI1);
  assign m3   = (cnt_q >= LO3)  && (cnt_q <= HI3);
  assign m4   = (cnt_q >= LO4)  && (cnt_q <= HI4);
  assign m8   = (cnt_q >= LO8)  && (cnt_q <= HI8);
  assign m16  = (cnt_q >= LO16) && (cnt_q <= HI16);

  always_comb begin
    addr_pub = shift_q[15:0];
    ext_pub  = 1'b0;
    chk_ok   = 1'b1;
`ifdef NEC_IR_DECODER_CHECK_EN
    chk_ok = (shift_q[31:24] == ~shift_q[23:16]);
    if (shift_q[15:8] == ~shift_q[7:0]) addr_pub = {8'h00, shift_q[7:0]};
    else                                 ext_pub  = 1'b1;
`endif
  end

  // cnt_q at an edge equals the length of the level that just ended
  always_comb begin
    cnt_d = cnt_q;
    if (rise || fall) cnt_d = CW'(1);
    else if (!sat)    cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    shift_d = shift_q;
    dv_d    = 1'b0;
    rep_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE:      if (rise) state_d = LEAD_MARK;
      LEAD_MARK: if (fall) state_d = m16 ? LEAD_SPACE : IDLE;
      LEAD_SPACE: begin
        if (rise) begin
          if (m8) begin
            bits_d  = '0;
            state_d = BIT_MARK;
          end else if (m4) begin
            state_d = REPEAT_MARK;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (sat) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      BIT_MARK: begin
        if (fall) begin
          state_d = m1 ? BIT_SPACE : IDLE;
          err_d   = ~m1;
        end
      end
      BIT_SPACE: begin
        if (rise) begin
          if (m1 || m3) begin
            shift_d = {m3, shift_q[31:1]};
            bits_d  = bits_q + 6'd1;
            state_d = (bits_q == 6'd31) ? STOP_MARK : BIT_MARK;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (sat) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      STOP_MARK: begin
        if (fall) begin
          dv_d    = m1 & chk_ok;
          err_d   = ~(m1 & chk_ok);
          state_d = IDLE;
        end
      end
      REPEAT_MARK: begin
        if (fall) begin
          rep_d   = m1 & held_q;
          err_d   = ~m1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A repeat landing on the expiry cycle reloads before the countdown clears heldOUT
  always_comb begin
    hold_d = hold_q;
    held_d = held_q;
    if (dv_d || rep_d) begin
      hold_d = HW'(HOLD);
      held_d = 1'b1;
    end else if (err_d) begin
      hold_d = '0;
      held_d = 1'b0;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
      held_d = (hold_q != HW'(1));
    end
  end

  always_ff @(posedge clkIN) begin
    if (resetIN) begin
      sync1_q <= RX_ACTIVE_LOW;
      sync2_q <= RX_ACTIVE_LOW;
      mark_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= IDLE;
      bits_q  <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      held_q  <= 1'b0;
      dv_q    <= 1'b0;
      rep_q   <= 1'b0;
      err_q   <= 1'b0;
      ext_q   <= 1'b0;
      addr_q  <= '0;
      cmd_q   <= '0;
      data_q  <= '0;
    end else begin
      sync1_q <= rxIN;
      sync2_q <= sync1_q;
      mark_q  <= mark;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      held_q  <= held_d;
      dv_q    <= dv_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
      if (dv_d) begin
        data_q <= shift_q;
        addr_q <= addr_pub;
        cmd_q  <= shift_q[23:16];
        ext_q  <= ext_pub;
      end
    end
  end

  assign dataValidOUT = dv_q;
  assign repeatOUT    = rep_q;
  assign errorOUT     = err_q;
  assign heldOUT      = held_q;
  assign extendedOUT  = ext_q;
  assign addressOUT   = addr_q;
  assign commandOUT   = cmd_q;
  assign dataOUT      = data_q;

endmodule
